// File: rtl/spart_rx.sv
// SPART receive half: de-serialises 8N1 frames using the 16x oversampling enable
// from baud_gen and presents the byte plus RDA / framing / overrun flags.
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud,
  input  logic                 rxd,
  input  logic                 read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 s1, rxs;
  logic                 frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rxd;
      rxs <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tick   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      tick   <= tick_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
    end
  end

  // Tick counter is a power-of-two width, so DATA/STOP wrap 15->0 for free.
  always_comb begin
    state_n    = state;
    tick_n     = tick;
    bitcnt_n   = bitcnt;
    shreg_n    = shreg;
    frame_done = 1'b0;
    if (baud) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          tick_n = tick + 1'b1;
          if (tick == HALF_M1) begin
            tick_n = '0;
            if (!rxs) begin
              state_n  = DATA;
              bitcnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DATA: begin
          tick_n = tick + 1'b1;
          if (tick == LAST) begin
            shreg_n[bitcnt] = rxs;
            bitcnt_n        = bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) begin
              state_n  = STOP;
              bitcnt_n = '0;
            end
          end
        end
        STOP: begin
          tick_n = tick + 1'b1;
          if (tick == LAST) begin
            frame_done = 1'b1;
            state_n    = rxs ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not look like a fresh start bit.
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A read in the same cycle as frame completion frees the buffer first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (read) begin
        rda         <= 1'b0;
        overrun     <= 1'b0;
        framing_err <= 1'b0;
      end
      if (frame_done) begin
        if (!rda || read) begin
          rx_data     <= shreg;
          rda         <= 1'b1;
          framing_err <= ~rxs;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Randomised scoreboard bench for spart_rx: a frame-level model predicts the
// visible output state, a monitor pops predictions whenever the outputs change.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud = 1'b0;
  logic       rxd = 1'b1;
  logic       read = 1'b0;
  logic [7:0] rx_data;
  logic       rda, framing_err, overrun;

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .baud(baud), .rxd(rxd), .read(read),
    .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model of the visible receive buffer: {data, rda, framing_err, overrun}
  logic [7:0]  m_data = '0;
  logic        m_rda = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic [10:0] m_last = '0;
  logic [10:0] exp_q[$];

  logic [10:0] dut_state;
  logic [10:0] seen = '0;
  logic [10:0] last_exp = '0;
  logic        mon_en = 1'b0;
  assign dut_state = {rx_data, rda, framing_err, overrun};

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got data=%h rda=%b fe=%b ov=%b, expected data=%h rda=%b fe=%b ov=%b",
                  name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic model_push();
    logic [10:0] cur;
    cur = {m_data, m_rda, m_fe, m_ov};
    if (cur != m_last) begin
      exp_q.push_back(cur);
      m_last = cur;
    end
  endtask

  task automatic model_read();
    m_rda = 1'b0;
    m_ov  = 1'b0;
    m_fe  = 1'b0;
    model_push();
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic rd_same);
    if (rd_same) begin
      m_rda = 1'b0;
      m_ov  = 1'b0;
      m_fe  = 1'b0;
    end
    if (!m_rda) begin
      m_data = d;
      m_rda  = 1'b1;
      m_fe   = !stop_ok;
    end else begin
      m_ov = 1'b1;
    end
    model_push();
  endtask

  // One baud period (4 clks): rxd level for this tick, optional read/rst on the baud clk.
  task automatic applyStimulus(input logic rx_v, input logic rd, input logic rs);
    @(negedge clk);
    rxd  = rx_v;
    baud = 1'b1;
    read = rd;
    rst  = rs;
    @(negedge clk);
    baud = 1'b0;
    read = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_read();
    @(negedge clk);
    read = 1'b1;
    model_read();
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  // Start bit is driven at tick 0 and seen one tick later; the stop sample lands at tick 153.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic collide,
                            input int rst_tick, input int extra_low);
    logic bitv;
    if (rst_tick >= 0) begin
      m_data = '0;
      m_rda  = 1'b0;
      m_fe   = 1'b0;
      m_ov   = 1'b0;
      model_push();
    end else begin
      model_frame(d, stop_ok, collide);
    end
    for (int i = 0; i < 160; i++) begin
      if (i < 16) bitv = 1'b0;
      else if (i < 144) bitv = d[(i / 16) - 1];
      else bitv = stop_ok;
      applyStimulus(bitv, collide && (i == 153), i == rst_tick);
    end
    for (int i = 0; i < extra_low; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en && dut_state !== seen) begin
      seen = dut_state;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_change", dut_state, last_exp);
      end else begin
        last_exp = exp_q.pop_front();
        checkOutput("scoreboard", dut_state, last_exp);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       ok, col;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", dut_state, 11'd0);
    seen   = dut_state;
    mon_en = 1'b1;
    idle(4);

    send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
    idle(5);
    do_read();
    idle(3);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, -1, 0);
    idle(3);
    do_read();

    send_frame(8'h55, 1'b0, 1'b0, -1, 40);
    idle(3);
    do_read();
    send_frame(8'h0F, 1'b1, 1'b0, -1, 0);
    idle(3);
    do_read();

    send_frame(8'h11, 1'b1, 1'b0, -1, 0);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b0, -1, 0);
    idle(2);
    do_read();

    send_frame(8'h11, 1'b1, 1'b0, -1, 0);
    idle(2);
    send_frame(8'h77, 1'b1, 1'b1, -1, 0);
    idle(2);

    send_frame(8'hFF, 1'b1, 1'b0, 85, 0);
    idle(4);
    send_frame(8'h81, 1'b1, 1'b0, -1, 0);
    idle(3);

    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      col = m_rda && ($urandom_range(0, 3) == 0);
      send_frame(d, ok, col, -1, ok ? 0 : $urandom_range(0, 30));
      idle($urandom_range(1, 10));
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        idle(1);
      end
    end

    idle(10);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL pending_expectations: got %0d unconsumed, expected 0", exp_q.size());
    checkOutput("final_state", dut_state, {m_data, m_rda, m_fe, m_ov});
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
